// File: rtl/tick_generator_if.sv
// Control/status bundle for tick_generator: the master drives start/stop/period,
// and the slave (the generator) returns the clock-enable pulse and status.
interface tick_generator_if #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 4
);
  logic                 start;
  logic                 stop;
  logic                 oneshot;
  logic [WIDTH-1:0]     load_val;
  logic                 ce_out;
  logic                 busy;
  logic [CNT_WIDTH-1:0] tick_cnt;

  modport master (
    output start, stop, oneshot, load_val,
    input  ce_out, busy, tick_cnt
  );

  modport slave (
    input  start, stop, oneshot, load_val,
    output ce_out, busy, tick_cnt
  );
endinterface

// File: rtl/tick_generator.sv
// Programmable tick generator: emits a one-cycle ce_out every L+1 cycles (periodic)
// or once (oneshot), counting emitted ticks since the last accepted start.
module tick_generator #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  tick_generator_if.slave     bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t               r_state, w_state_nxt;
  logic [WIDTH-1:0]     r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]     r_per, w_per_nxt;
  logic                 r_os, w_os_nxt;
  logic [CNT_WIDTH-1:0] r_tick_cnt, w_tick_cnt_nxt;
  logic                 r_ce, w_ce_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_per      <= '0;
      r_os       <= 1'b0;
      r_tick_cnt <= '0;
      r_ce       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_per      <= w_per_nxt;
      r_os       <= w_os_nxt;
      r_tick_cnt <= w_tick_cnt_nxt;
      r_ce       <= w_ce_nxt;
    end
  end

  // stop beats start beats counting; the tick fires on the edge that finds cnt==0,
  // so a period of L gives L+1 cycles between ticks without widening the counter.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_per_nxt      = r_per;
    w_os_nxt       = r_os;
    w_tick_cnt_nxt = r_tick_cnt;
    w_ce_nxt       = 1'b0;
    if (bus.stop) begin
      w_state_nxt = IDLE;
    end else if (bus.start) begin
      w_state_nxt    = RUN;
      w_cnt_nxt      = bus.load_val;
      w_per_nxt      = bus.load_val;
      w_os_nxt       = bus.oneshot;
      w_tick_cnt_nxt = '0;
    end else if (r_state == RUN) begin
      if (r_cnt != '0) begin
        w_cnt_nxt = r_cnt - 1'b1;
      end else begin
        w_ce_nxt       = 1'b1;
        w_tick_cnt_nxt = r_tick_cnt + 1'b1;
        if (r_os) w_state_nxt = IDLE;
        else      w_cnt_nxt   = r_per;
      end
    end
  end

  assign bus.ce_out   = r_ce;
  assign bus.busy     = (r_state == RUN);
  assign bus.tick_cnt = r_tick_cnt;

endmodule

// File: tb/tb_tick_generator.sv
// Directed bench for tick_generator: reset, periodic/oneshot timing, boundaries,
// restart/priority, async reset and a modulo-4 counter driven by ce_out.
module tb_tick_generator;
  localparam int WIDTH     = 8;
  localparam int CNT_WIDTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [1:0] mod4;

  tick_generator_if #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

  tick_generator #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Downstream consumer: a modulo-4 counter enabled by ce_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              mod4 <= 2'd0;
    else if (bus.ce_out)  mod4 <= mod4 + 2'd1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ce, input logic bsy, input int tc);
    chk({tag, " ce"},   {31'd0, bus.ce_out}, {31'd0, ce});
    chk({tag, " busy"}, {31'd0, bus.busy},   {31'd0, bsy});
    chk({tag, " tcnt"}, {28'd0, bus.tick_cnt}, tc[31:0]);
  endtask

  initial begin
    bus.start    = 1'b1;
    bus.stop     = 1'b0;
    bus.oneshot  = 1'b0;
    bus.load_val = 8'd3;

    // Reset held with start asserted: must stay idle
    #3;
    chk_out("reset", 1'b0, 1'b0, 0);
    step(); step();
    chk_out("reset start ignored", 1'b0, 1'b0, 0);
    bus.start = 1'b0;
    #2 rst = 1'b0;
    step(); step();
    chk_out("post reset idle", 1'b0, 1'b0, 0);

    // Periodic L=3; load_val/oneshot changes in RUN must be ignored
    bus.start = 1'b1; bus.load_val = 8'd3; bus.oneshot = 1'b0;
    step();
    bus.start = 1'b0; bus.load_val = 8'd9; bus.oneshot = 1'b1;
    chk("per start busy", {31'd0, bus.busy}, 32'd1);
    for (int n = 1; n <= 12; n++) begin
      step();
      chk_out($sformatf("per n=%0d", n), (n % 4) == 0, 1'b1, n / 4);
    end

    // Stop: idle, counters hold
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk_out("stop", 1'b0, 1'b0, 3);
    for (int n = 1; n <= 5; n++) step();
    chk_out("stopped stays idle", 1'b0, 1'b0, 3);

    // Oneshot L=5
    bus.start = 1'b1; bus.load_val = 8'd5; bus.oneshot = 1'b1;
    step();
    bus.start = 1'b0; bus.oneshot = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      step();
      chk_out($sformatf("os n=%0d", n), n == 6, n < 6, (n >= 6) ? 1 : 0);
    end

    // L=0 periodic: continuous ce, tick_cnt wraps 15 -> 0
    bus.start = 1'b1; bus.load_val = 8'd0; bus.oneshot = 1'b0;
    step();
    bus.start = 1'b0;
    chk("l0 first cycle ce", {31'd0, bus.ce_out}, 32'd0);
    for (int n = 1; n <= 20; n++) begin
      step();
      chk_out($sformatf("l0 n=%0d", n), 1'b1, 1'b1, n % 16);
    end

    // L=255: period of 256 cycles
    bus.start = 1'b1; bus.load_val = 8'd255;
    step();
    bus.start = 1'b0;
    for (int n = 1; n <= 512; n++) begin
      step();
      chk($sformatf("l255 ce n=%0d", n), {31'd0, bus.ce_out}, {31'd0, (n % 256) == 0});
    end
    chk("l255 tcnt", {28'd0, bus.tick_cnt}, 32'd2);

    // Restart at L=7 two cycles before a pending tick (L=3 tick due at n=4)
    bus.start = 1'b1; bus.load_val = 8'd3;
    step();
    bus.start = 1'b0;
    step();
    bus.start = 1'b1; bus.load_val = 8'd7;
    step();
    bus.start = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      step();
      chk_out($sformatf("restart n=%0d", n), n == 8, 1'b1, (n >= 8) ? 1 : 0);
    end

    // start and stop together: stop wins
    bus.start = 1'b1; bus.stop = 1'b1; bus.load_val = 8'd0;
    step();
    bus.start = 1'b0; bus.stop = 1'b0;
    chk_out("start+stop", 1'b0, 1'b0, 1);
    for (int n = 1; n <= 3; n++) begin
      step();
      chk_out($sformatf("start+stop idle n=%0d", n), 1'b0, 1'b0, 1);
    end

    // Async reset mid-RUN while ce_out is high and cnt has been reloaded to 2
    bus.start = 1'b1; bus.load_val = 8'd2;
    step();
    bus.start = 1'b0;
    step(); step(); step();
    chk_out("pre async rst", 1'b1, 1'b1, 1);
    #2 rst = 1'b1;
    #1;
    chk_out("async rst", 1'b0, 1'b0, 0);
    #2 rst = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      step();
      chk_out($sformatf("after rst n=%0d", n), 1'b0, 1'b0, 0);
    end

    // Integration: L=1 drives a mod-4 counter, advancing every 2 cycles
    chk("mod4 init", {30'd0, mod4}, 32'd0);
    bus.start = 1'b1; bus.load_val = 8'd1; bus.oneshot = 1'b0;
    step();
    bus.start = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      step();
      chk($sformatf("mod4 n=%0d", n), {30'd0, mod4}, ((n - 1) / 2) % 4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety bound so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
